// File: rtl/uart_port_bridge_if.sv
// Signal bundle between the UART debug bridge and its neighbours: byte stream in,
// response byte out, and the SoC port bus the bridge masters.
interface uart_port_bridge_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] in_port;
  logic       overrun;

  modport master (
    input  rx_data, rx_valid, tx_ready, in_port,
    output tx_data, tx_valid, port_id, out_port, write_strobe, read_strobe, overrun
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, in_port,
    input  tx_data, tx_valid, port_id, out_port, write_strobe, read_strobe, overrun
  );
endinterface

// File: rtl/uart_port_bridge.sv
// UART-driven debug master: parses 'W' port data / 'R' port frames into single-cycle
// port-bus strobes and answers every command with one response byte.
module uart_port_bridge #(
  parameter int         READ_WAIT      = 0,
  parameter int         TIMEOUT_CYCLES = 65535,
  parameter logic [7:0] ACK_BYTE       = 8'h06,
  parameter logic [7:0] NAK_BYTE       = 8'h15
) (
  input logic clk,
  input logic reset,
  uart_port_bridge_if.master bus
);
  localparam logic [7:0]  CMD_WR    = 8'h57;
  localparam logic [7:0]  CMD_RD    = 8'h52;
  localparam logic [15:0] TO_LIMIT  = 16'(TIMEOUT_CYCLES);
  localparam logic [15:0] WAIT_LAST = 16'(READ_WAIT - 1);

  typedef enum logic [2:0] {IDLE, GET_PORT, GET_DATA, BUS_WR, BUS_RD, RD_WAIT, SEND} state_t;

  state_t      state, state_n;
  logic        is_wr, is_wr_n;
  logic [15:0] cnt, cnt_n;
  logic [7:0]  port_id, port_id_n;
  logic [7:0]  out_port, out_port_n;
  logic [7:0]  tx_data, tx_data_n;
  logic        overrun, overrun_n;
  logic        busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      is_wr    <= 1'b0;
      cnt      <= '0;
      port_id  <= '0;
      out_port <= '0;
      tx_data  <= '0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_n;
      is_wr    <= is_wr_n;
      cnt      <= cnt_n;
      port_id  <= port_id_n;
      out_port <= out_port_n;
      tx_data  <= tx_data_n;
      overrun  <= overrun_n;
    end
  end

  assign busy = (state == BUS_WR) || (state == BUS_RD) || (state == RD_WAIT) || (state == SEND);

  // cnt doubles as the inter-byte timeout in the GET states and the read-wait count in RD_WAIT
  always_comb begin
    state_n    = state;
    is_wr_n    = is_wr;
    cnt_n      = cnt;
    port_id_n  = port_id;
    out_port_n = out_port;
    tx_data_n  = tx_data;
    overrun_n  = overrun;
    case (state)
      IDLE: begin
        if (bus.rx_valid) begin
          cnt_n = '0;
          if (bus.rx_data == CMD_WR || bus.rx_data == CMD_RD) begin
            is_wr_n = (bus.rx_data == CMD_WR);
            state_n = GET_PORT;
          end else begin
            tx_data_n = NAK_BYTE;
            state_n   = SEND;
          end
        end
      end
      GET_PORT, GET_DATA: begin
        if (bus.rx_valid) begin
          cnt_n = '0;
          if (state == GET_PORT) begin
            port_id_n = bus.rx_data;
            state_n   = is_wr ? GET_DATA : BUS_RD;
          end else begin
            out_port_n = bus.rx_data;
            state_n    = BUS_WR;
          end
        end else if (cnt == TO_LIMIT) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      BUS_WR: begin
        tx_data_n = ACK_BYTE;
        state_n   = SEND;
      end
      BUS_RD: begin
        cnt_n = '0;
        if (READ_WAIT == 0) begin
          tx_data_n = bus.in_port;
          state_n   = SEND;
        end else begin
          state_n = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt == WAIT_LAST) begin
          cnt_n     = '0;
          tx_data_n = bus.in_port;
          state_n   = SEND;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      SEND: begin
        if (bus.tx_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (busy && bus.rx_valid) overrun_n = 1'b1;
  end

  assign bus.tx_data      = tx_data;
  assign bus.tx_valid     = (state == SEND);
  assign bus.port_id      = port_id;
  assign bus.out_port     = out_port;
  assign bus.write_strobe = (state == BUS_WR);
  assign bus.read_strobe  = (state == BUS_RD);
  assign bus.overrun      = overrun;
endmodule

// File: tb/tb_uart_port_bridge.sv
// Bench for uart_port_bridge: two instances (READ_WAIT 0 and 3) share one stimulus stream;
// observed strobes/responses are compared with a frame-level reference model.
module tb_uart_port_bridge;
  localparam int TO = 100;
  localparam int RW_A = 0;
  localparam int RW_B = 3;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] in_port = 8'h00;
  logic rx_valid = 1'b0;
  logic tx_ready = 1'b0;
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_port_bridge_if ifa ();
  uart_port_bridge_if ifb ();
  assign ifa.rx_data = rx_data;   assign ifb.rx_data = rx_data;
  assign ifa.rx_valid = rx_valid; assign ifb.rx_valid = rx_valid;
  assign ifa.tx_ready = tx_ready; assign ifb.tx_ready = tx_ready;
  assign ifa.in_port = in_port;   assign ifb.in_port = in_port;

  uart_port_bridge #(.READ_WAIT(RW_A), .TIMEOUT_CYCLES(TO)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  uart_port_bridge #(.READ_WAIT(RW_B), .TIMEOUT_CYCLES(TO)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  logic [1:0] ws, rs, tv, ov;
  logic [1:0][7:0] pid, pout, td;
  assign ws   = {ifb.write_strobe, ifa.write_strobe};
  assign rs   = {ifb.read_strobe, ifa.read_strobe};
  assign tv   = {ifb.tx_valid, ifa.tx_valid};
  assign ov   = {ifb.overrun, ifa.overrun};
  assign pid  = {ifb.port_id, ifa.port_id};
  assign pout = {ifb.out_port, ifa.out_port};
  assign td   = {ifb.tx_data, ifa.tx_data};

  // kind: 1 write strobe, 2 read strobe, 0 response byte
  typedef struct {int dut; int cyc; int kind; logic [7:0] a; logic [7:0] d;} ev_t;
  typedef struct {int kind; int s_cyc; logic [7:0] port; logic [7:0] data; int t_cyc; logic [7:0] t_data;} exp_t;

  ev_t bus_q[$];
  ev_t tx_q[$];
  logic [7:0] inp_log [int];
  int viol = 0;
  logic [1:0] pws = '0, prs = '0, ptv = '0, pacc = '0;
  logic [1:0][7:0] ppid = '0, ppout = '0, ptd = '0;

  always @(negedge clk) begin
    inp_log[cyc] = in_port;
    for (int d = 0; d < 2; d++) begin
      if (ws[d]) bus_q.push_back('{d, cyc, 1, pid[d], pout[d]});
      if (rs[d]) bus_q.push_back('{d, cyc, 2, pid[d], 8'h00});
      if (ws[d] && rs[d]) begin
        viol++; $display("protocol violation dut%0d cyc %0d: both strobes high", d, cyc);
      end
      if ((ws[d] && pws[d]) || (rs[d] && prs[d])) begin
        viol++; $display("protocol violation dut%0d cyc %0d: strobe longer than one cycle", d, cyc);
      end
      if (pws[d] && !reset && (pid[d] !== ppid[d] || pout[d] !== ppout[d])) begin
        viol++; $display("protocol violation dut%0d cyc %0d: port/data moved after write", d, cyc);
      end
      if (tv[d] && !ptv[d]) tx_q.push_back('{d, cyc, 0, td[d], 8'h00});
      if (tv[d] && ptv[d] && !pacc[d] && td[d] !== ptd[d]) begin
        viol++; $display("protocol violation dut%0d cyc %0d: tx_data %h -> %h while pending", d, cyc, ptd[d], td[d]);
      end
      if (pacc[d] && tv[d]) begin
        viol++; $display("protocol violation dut%0d cyc %0d: tx_valid held after accept", d, cyc);
      end
      pws[d] = ws[d]; prs[d] = rs[d]; ptv[d] = tv[d];
      ppid[d] = pid[d]; ppout[d] = pout[d]; ptd[d] = td[d];
      pacc[d] = tv[d] && tx_ready;
    end
  end

  function automatic int rwof(input int d);
    return (d == 0) ? RW_A : RW_B;
  endfunction

  function automatic int count_ev(input ev_t q[$], input int d);
    int n = 0;
    foreach (q[i]) if (q[i].dut == d) n++;
    return n;
  endfunction

  function automatic ev_t first_ev(input ev_t q[$], input int d);
    ev_t e = '{-1, -1, -1, 8'h00, 8'h00};
    foreach (q[i]) if (q[i].dut == d) return q[i];
    return e;
  endfunction

  // Frame-level reference: what one frame, sent at the given cycles, should produce.
  function automatic exp_t model(input logic [7:0] b[$], input int t[$], input int rw);
    exp_t e;
    int need, last;
    e = '{kind:0, s_cyc:-1, port:8'h00, data:8'h00, t_cyc:-1, t_data:8'h00};
    if (b.size() == 0) return e;
    if (b[0] != 8'h57 && b[0] != 8'h52) begin
      e.kind = 3; e.t_cyc = t[0] + 1; e.t_data = NAK;
      return e;
    end
    need = (b[0] == 8'h57) ? 3 : 2;
    if (b.size() < need) return e;
    for (int i = 1; i < need; i++) if (t[i] - t[i-1] > TO + 1) return e;
    last = t[need-1];
    e.port = b[1]; e.s_cyc = last + 1;
    if (b[0] == 8'h57) begin
      e.kind = 1; e.data = b[2]; e.t_cyc = last + 2; e.t_data = ACK;
    end else begin
      e.kind = 2; e.t_cyc = last + 2 + rw;
      e.t_data = inp_log.exists(last + 1 + rw) ? inp_log[last + 1 + rw] : 8'hxx;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [7:0] b[$], input int gap, output int t[$]);
    t = {};
    for (int i = 0; i < b.size(); i++) begin
      rx_valid = 1'b1; rx_data = b[i]; t.push_back(cyc);
      tick();
      rx_valid = 1'b0;
      if (i < b.size() - 1) repeat (gap - 1) tick();
    end
  endtask

  task automatic respond(input int hold);
    repeat (hold) tick();
    tx_ready = 1'b1; tick();
    tx_ready = 1'b0; tick();
  endtask

  task automatic test_reset();
    logic [27:0] got;
    reset = 1'b1; repeat (3) tick();
    reset = 1'b0; tick();
    for (int d = 0; d < 2; d++) begin
      got = {td[d], pid[d], pout[d], tv[d], ws[d], rs[d], ov[d]};
      checks++;
      if (got !== 28'h0) begin
        failures++; $display("FAIL reset_values dut%0d got=%h exp=0000000", d, got);
      end
    end
  endtask

  task automatic test_write();
    for (int n = 0; n < 4; n++) begin
      logic [7:0] b[$];
      int t[$];
      exp_t e;
      ev_t ev;
      bus_q.delete(); tx_q.delete();
      b = {8'h57, (n == 0) ? 8'h0A : 8'($urandom), (n == 0) ? 8'h41 : 8'($urandom)};
      send_frame(b, (n == 0) ? 10 : int'($urandom_range(1, 12)), t);
      respond(5 + int'($urandom_range(0, 10)));
      for (int d = 0; d < 2; d++) begin
        e = model(b, t, rwof(d));
        checks++;
        if (count_ev(bus_q, d) !== 1) begin
          failures++; $display("FAIL write_strobe_count dut%0d got=%0d exp=1", d, count_ev(bus_q, d));
        end
        ev = first_ev(bus_q, d);
        checks++;
        if (ev.kind !== 1 || ev.cyc !== e.s_cyc || ev.a !== e.port || ev.d !== e.data) begin
          failures++;
          $display("FAIL write_strobe dut%0d got kind=%0d cyc=%0d port=%h data=%h exp kind=1 cyc=%0d port=%h data=%h",
                   d, ev.kind, ev.cyc, ev.a, ev.d, e.s_cyc, e.port, e.data);
        end
        ev = first_ev(tx_q, d);
        checks++;
        if (count_ev(tx_q, d) !== 1 || ev.cyc !== e.t_cyc || ev.a !== e.t_data) begin
          failures++;
          $display("FAIL write_ack dut%0d got n=%0d cyc=%0d data=%h exp n=1 cyc=%0d data=%h",
                   d, count_ev(tx_q, d), ev.cyc, ev.a, e.t_cyc, e.t_data);
        end
      end
      checks++;
      if (tv !== 2'b00) begin
        failures++; $display("FAIL write_tx_release got=%b exp=00", tv);
      end
    end
  endtask

  task automatic test_read();
    for (int n = 0; n < 3; n++) begin
      logic [7:0] b[$];
      int t[$];
      exp_t e;
      ev_t ev;
      bus_q.delete(); tx_q.delete();
      in_port = (n == 0) ? 8'h5A : 8'($urandom);
      b = {8'h52, (n == 0) ? 8'h0C : 8'($urandom)};
      send_frame(b, int'($urandom_range(1, 10)), t);
      respond(5 + int'($urandom_range(0, 6)));
      for (int d = 0; d < 2; d++) begin
        e = model(b, t, rwof(d));
        ev = first_ev(bus_q, d);
        checks++;
        if (count_ev(bus_q, d) !== 1 || ev.kind !== 2 || ev.cyc !== e.s_cyc || ev.a !== e.port) begin
          failures++;
          $display("FAIL read_strobe dut%0d got n=%0d kind=%0d cyc=%0d port=%h exp n=1 kind=2 cyc=%0d port=%h",
                   d, count_ev(bus_q, d), ev.kind, ev.cyc, ev.a, e.s_cyc, e.port);
        end
        ev = first_ev(tx_q, d);
        checks++;
        if (count_ev(tx_q, d) !== 1 || ev.cyc !== e.t_cyc || ev.a !== e.t_data) begin
          failures++;
          $display("FAIL read_data dut%0d got n=%0d cyc=%0d data=%h exp n=1 cyc=%0d data=%h",
                   d, count_ev(tx_q, d), ev.cyc, ev.a, e.t_cyc, e.t_data);
        end
      end
    end
  endtask

  task automatic test_read_wait();
    logic [7:0] b[$];
    int t[$];
    exp_t e;
    ev_t ev;
    logic [7:0] want [2];
    bus_q.delete(); tx_q.delete();
    in_port = 8'h00;
    b = {8'h52, 8'h0C};
    send_frame(b, 10, t);
    tick(); tick();
    in_port = 8'h5A;
    respond(3);
    // the zero-wait bridge samples before the change, the three-wait one after it
    want[0] = 8'h00; want[1] = 8'h5A;
    for (int d = 0; d < 2; d++) begin
      e = model(b, t, rwof(d));
      ev = first_ev(tx_q, d);
      checks++;
      if (ev.cyc !== t[1] + 2 + rwof(d) || ev.a !== want[d] || e.t_data !== want[d]) begin
        failures++;
        $display("FAIL read_wait dut%0d got cyc=%0d data=%h exp cyc=%0d data=%h",
                 d, ev.cyc, ev.a, t[1] + 2 + rwof(d), want[d]);
      end
    end
  endtask

  task automatic test_nak();
    for (int n = 0; n < 2; n++) begin
      logic [7:0] b[$];
      logic [7:0] x;
      int t[$];
      ev_t ev;
      bus_q.delete(); tx_q.delete();
      x = 8'h33;
      if (n > 0) do x = 8'($urandom); while (x == 8'h57 || x == 8'h52);
      b = {x};
      send_frame(b, 1, t);
      repeat (20) tick();
      checks++;
      if (tv !== 2'b11 || td[0] !== NAK || td[1] !== NAK) begin
        failures++; $display("FAIL nak_hold got valid=%b data=%h/%h exp valid=11 data=%h", tv, td[0], td[1], NAK);
      end
      respond(0);
      for (int d = 0; d < 2; d++) begin
        ev = first_ev(tx_q, d);
        checks++;
        if (count_ev(tx_q, d) !== 1 || count_ev(bus_q, d) !== 0 || ev.cyc !== t[0] + 1 || ev.a !== NAK) begin
          failures++;
          $display("FAIL nak_resp dut%0d got n=%0d strobes=%0d cyc=%0d data=%h exp n=1 strobes=0 cyc=%0d data=%h",
                   d, count_ev(tx_q, d), count_ev(bus_q, d), ev.cyc, ev.a, t[0] + 1, NAK);
        end
      end
    end
  endtask

  task automatic test_timeout();
    logic [7:0] b[$];
    int t[$];
    exp_t e;
    ev_t ev;
    bus_q.delete(); tx_q.delete();
    b = {8'h57, 8'h01};
    send_frame(b, 10, t);
    repeat (2 * TO) tick();
    checks++;
    if (bus_q.size() !== 0 || tx_q.size() !== 0) begin
      failures++; $display("FAIL timeout_silent got strobes=%0d resp=%0d exp 0/0", bus_q.size(), tx_q.size());
    end
    in_port = 8'($urandom);
    b = {8'h52, 8'h06};
    send_frame(b, 3, t);
    respond(6);
    for (int d = 0; d < 2; d++) begin
      e = model(b, t, rwof(d));
      ev = first_ev(tx_q, d);
      checks++;
      if (count_ev(bus_q, d) !== 1 || first_ev(bus_q, d).a !== 8'h06 || ev.a !== e.t_data || ev.cyc !== e.t_cyc) begin
        failures++;
        $display("FAIL timeout_recover dut%0d got strobes=%0d cyc=%0d data=%h exp strobes=1 cyc=%0d data=%h",
                 d, count_ev(bus_q, d), ev.cyc, ev.a, e.t_cyc, e.t_data);
      end
    end
  endtask

  task automatic test_overrun();
    logic [7:0] b[$];
    int t[$];
    bus_q.delete(); tx_q.delete();
    b = {8'h41};
    send_frame(b, 1, t);
    tick();
    rx_valid = 1'b1; rx_data = 8'h57;
    tick();
    rx_valid = 1'b0;
    tick();
    checks++;
    if (ov !== 2'b11) begin
      failures++; $display("FAIL overrun_set got=%b exp=11", ov);
    end
    respond(4);
    checks++;
    if (tx_q.size() !== 2 || tx_q[0].a !== NAK || tx_q[1].a !== NAK || bus_q.size() !== 0) begin
      failures++; $display("FAIL overrun_resp got resp=%0d strobes=%0d exp resp=2 data=%h strobes=0",
                           tx_q.size(), bus_q.size(), NAK);
    end
    b = {8'h52, 8'($urandom)};
    send_frame(b, 2, t);
    respond(6);
    checks++;
    if (ov !== 2'b11 || bus_q.size() !== 2) begin
      failures++; $display("FAIL overrun_sticky got ov=%b strobes=%0d exp ov=11 strobes=2", ov, bus_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b[$];
    logic [27:0] got;
    int t[$];
    bus_q.delete(); tx_q.delete();
    b = {8'h57, 8'($urandom | 1)};
    send_frame(b, 4, t);
    repeat (3) tick();
    rx_valid = 1'b1; rx_data = 8'($urandom); reset = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
    reset = 1'b0;
    repeat (5) tick();
    checks++;
    if (bus_q.size() !== 0 || tx_q.size() !== 0) begin
      failures++; $display("FAIL reset_mid_events got strobes=%0d resp=%0d exp 0/0", bus_q.size(), tx_q.size());
    end
    for (int d = 0; d < 2; d++) begin
      got = {td[d], pid[d], pout[d], tv[d], ws[d], rs[d], ov[d]};
      checks++;
      if (got !== 28'h0) begin
        failures++; $display("FAIL reset_mid_values dut%0d got=%h exp=0000000", d, got);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 10; n++) begin
      logic [7:0] b[$];
      logic [7:0] x;
      int t[$];
      int k;
      exp_t e;
      ev_t ev;
      bus_q.delete(); tx_q.delete();
      in_port = 8'($urandom);
      k = int'($urandom_range(0, 2));
      if (k == 0) b = {8'h57, 8'($urandom), 8'($urandom)};
      else if (k == 1) b = {8'h52, 8'($urandom)};
      else begin
        do x = 8'($urandom); while (x == 8'h57 || x == 8'h52);
        b = {x};
      end
      send_frame(b, int'($urandom_range(1, 4)), t);
      respond(5 + int'($urandom_range(0, 3)));
      for (int d = 0; d < 2; d++) begin
        e = model(b, t, rwof(d));
        ev = first_ev(bus_q, d);
        checks++;
        if (count_ev(bus_q, d) !== ((e.kind == 1 || e.kind == 2) ? 1 : 0) ||
            (e.kind inside {1, 2} && (ev.kind !== e.kind || ev.cyc !== e.s_cyc || ev.a !== e.port ||
                                      (e.kind == 1 && ev.d !== e.data)))) begin
          failures++;
          $display("FAIL b2b_strobe frame%0d dut%0d got n=%0d kind=%0d cyc=%0d port=%h data=%h exp kind=%0d cyc=%0d port=%h data=%h",
                   n, d, count_ev(bus_q, d), ev.kind, ev.cyc, ev.a, ev.d, e.kind, e.s_cyc, e.port, e.data);
        end
        ev = first_ev(tx_q, d);
        checks++;
        if (count_ev(tx_q, d) !== 1 || ev.cyc !== e.t_cyc || ev.a !== e.t_data) begin
          failures++;
          $display("FAIL b2b_resp frame%0d dut%0d got n=%0d cyc=%0d data=%h exp n=1 cyc=%0d data=%h",
                   n, d, count_ev(tx_q, d), ev.cyc, ev.a, e.t_cyc, e.t_data);
        end
      end
    end
    checks++;
    if (ov !== 2'b00) begin
      failures++; $display("FAIL b2b_no_overrun got=%b exp=00", ov);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick();
    test_reset();
    test_write();
    test_read();
    test_read_wait();
    test_nak();
    test_timeout();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (viol != 0) begin
      failures++; $display("FAIL protocol_monitor got=%0d violations exp=0", viol);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
